// File: rtl/shift_sequencer_pkg.sv
// Shared definitions for the multi-cycle shift sequencer.
// Opcode and state encodings plus the default datapath width.
package shift_pkg;

  localparam int WIDTH_DEF = 32;

  localparam logic OP_SLL = 1'b0;
  localparam logic OP_SRA = 1'b1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/shift_sequencer_if.sv
// Request/result handshake bundle for the shift sequencer.
// master = issue/writeback side, slave = shift_sequencer.
interface shift_sequencer_if
  import shift_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  localparam int SHW = $clog2(WIDTH)
);

  logic             in_valid;
  logic             in_ready;
  logic             in_op;
  logic [WIDTH-1:0] in_data;
  logic [SHW-1:0]   in_shamt;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             busy;

  modport master (
    output in_valid, in_op, in_data, in_shamt,
    output out_ready,
    input  in_ready, out_valid, out_data, busy
  );

  modport slave (
    input  in_valid, in_op, in_data, in_shamt,
    input  out_ready,
    output in_ready, out_valid, out_data, busy
  );

endinterface

// File: rtl/shift_sequencer_stage_mux.sv
// One power-of-two shift stage, selected by binary stage index.
// Each fixed stage shifts by 2^k; SRA replicates the MSB.
module shift_stage_mux
  import shift_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  localparam int SHW = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] i_acc,
  input  logic             i_op,
  input  logic [SHW-1:0]   i_b,
  output logic [WIDTH-1:0] o_acc
);

  logic [WIDTH-1:0] w_stg [SHW];

  for (genvar k = 0; k < SHW; k++) begin : g_stg
    localparam int unsigned D = 1 << k;
    assign w_stg[k] = (i_op == OP_SRA)
                    ? WIDTH'($signed(i_acc) >>> D)
                    : (i_acc << D);
  end

  always_comb begin
    o_acc = i_acc;
    for (int k = 0; k < SHW; k++) begin
      if (i_b == SHW'(k)) o_acc = w_stg[k];
    end
  end

endmodule

// File: rtl/shift_sequencer.sv
// Multi-cycle shifter: one 2^b stage per clock for each set bit
// of the shift amount, highest bit first, between two handshakes.
module shift_sequencer
  import shift_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  localparam int SHW = $clog2(WIDTH)
) (
  input logic              clock,
  input logic              reset_n,
  shift_sequencer_if.slave bus
);

  state_e           r_state;
  state_e           w_nxt;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] w_acc_sh;
  logic [SHW-1:0]   r_rem;
  logic [SHW-1:0]   w_b;
  logic [SHW-1:0]   w_rem_clr;
  logic             r_op;
  logic             w_accept;

  // Priority encoder: highest set bit of rem wins.
  always_comb begin
    w_b = '0;
    for (int i = 0; i < SHW; i++) begin
      if (r_rem[i]) w_b = SHW'(i);
    end
  end

  assign w_rem_clr = r_rem & ~(SHW'(1) << w_b);
  assign w_accept  = (r_state == S_IDLE) && bus.in_valid;

  shift_stage_mux #(.WIDTH(WIDTH)) u_mux (
    .i_acc (r_acc),
    .i_op  (r_op),
    .i_b   (w_b),
    .o_acc (w_acc_sh)
  );

  always_comb begin
    w_nxt = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (bus.in_valid)
          w_nxt = (bus.in_shamt == '0) ? S_DONE : S_SHIFT;
      end
      S_SHIFT: begin
        if (w_rem_clr == '0) w_nxt = S_DONE;
      end
      S_DONE: begin
        if (bus.out_ready) w_nxt = S_IDLE;
      end
      default: w_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_nxt;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_acc <= '0;
      r_rem <= '0;
      r_op  <= OP_SLL;
    end else if (w_accept) begin
      r_acc <= bus.in_data;
      r_rem <= bus.in_shamt;
      r_op  <= bus.in_op;
    end else if (r_state == S_SHIFT) begin
      r_acc <= w_acc_sh;
      r_rem <= w_rem_clr;
    end
  end

  assign bus.in_ready  = (r_state == S_IDLE);
  assign bus.out_valid = (r_state == S_DONE);
  assign bus.busy      = (r_state != S_IDLE);
  assign bus.out_data  = r_acc;

endmodule
